// File: rtl/axon_spike_scheduler_pkg.sv
// Shared constants and types for the axon spike scheduler.
// NUM_AXONS lives here so the interface, encoder and top agree on the axon index width.
package axon_spike_scheduler_pkg;
  localparam int NUM_AXONS = 256;
  localparam int AXON_W    = $clog2(NUM_AXONS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ISSUE  = 2'd2,
    GAP    = 2'd3
  } state_e;
endpackage

// File: rtl/axon_spike_scheduler_if.sv
// Signal bundle between the spike source / synapse stage (master) and the scheduler (slave).
interface axon_spike_scheduler_if;
  import axon_spike_scheduler_pkg::*;

  // spike_in_valid is a one-cycle strobe with no ready: the scheduler accepts a spike on every
  // valid edge. The enable burst has no backpressure; synap_con_done is expected in the first GAP cycle.
  logic              spike_in_valid;
  logic [AXON_W-1:0] spike_in_axon;
  logic              tick;
  logic              synap_con_done;
  logic [AXON_W-1:0] axon_number;
  logic              enable;
  logic              busy;
  logic              tick_done;
  logic              tick_overrun;
  logic              sync_error;
  state_e            dbg_state;

  modport master (
    output spike_in_valid, spike_in_axon, tick, synap_con_done,
    input  axon_number, enable, busy, tick_done, tick_overrun, sync_error, dbg_state
  );

  modport slave (
    input  spike_in_valid, spike_in_axon, tick, synap_con_done,
    output axon_number, enable, busy, tick_done, tick_overrun, sync_error, dbg_state
  );
endinterface

// File: rtl/axon_spike_scheduler_priority_encoder.sv
// Combinational lowest-set-bit finder over the scan bank.
module axon_priority_encoder
  import axon_spike_scheduler_pkg::*;
(
  input  logic [NUM_AXONS-1:0] bits_i,
  output logic [AXON_W-1:0]    index_o,
  output logic                 found_o
);
  // Scanning downward lets the last hit, i.e. the lowest index, win.
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = NUM_AXONS - 1; i >= 0; i--) begin
      if (bits_i[i]) begin
        index_o = AXON_W'(i);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axon_spike_scheduler.sv
// Double-banked spike bitmap: the fill bank collects next-tick spikes while the scan bank
// is replayed one axon at a time as NUM_NEURONS-cycle enable bursts.
module axon_spike_scheduler
  import axon_spike_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int ISSUE_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  axon_spike_scheduler_if.slave   bus
);
  localparam int BW = $clog2(NUM_NEURONS) + 1;
  localparam int GW = $clog2(ISSUE_GAP) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(NUM_NEURONS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(ISSUE_GAP - 1);

  state_e                state_q, state_d;
  logic [NUM_AXONS-1:0]  bank_q [2];
  logic [NUM_AXONS-1:0]  bank_d [2];
  logic                  sel_q, sel_d;
  logic [AXON_W-1:0]     axon_q, axon_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  enable_q, tick_done_q, tick_overrun_q;
  logic [NUM_AXONS-1:0]  scan_bits;
  logic [AXON_W-1:0]     enc_idx;
  logic                  enc_found;

  // sel_q names the fill bank; the other bank is the one being replayed.
  assign scan_bits = bank_q[~sel_q];

  axon_priority_encoder u_enc (
    .bits_i  (scan_bits),
    .index_o (enc_idx),
    .found_o (enc_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    axon_d  = axon_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          sel_d          = ~sel_q;
          bank_d[~sel_q] = '0;
          state_d        = SEARCH;
        end
      end
      SEARCH: begin
        if (enc_found) begin
          axon_d                  = enc_idx;
          bank_d[~sel_q][enc_idx] = 1'b0;
          burst_d                 = '0;
          state_d                 = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (burst_q == BURST_LAST) begin
          gap_d   = '0;
          state_d = GAP;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = SEARCH;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Applied after the swap so a spike in the swap cycle lands in the new fill bank.
    if (bus.spike_in_valid) bank_d[sel_d][bus.spike_in_axon] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      sel_q          <= 1'b0;
      bank_q[0]      <= '0;
      bank_q[1]      <= '0;
      axon_q         <= '0;
      burst_q        <= '0;
      gap_q          <= '0;
      enable_q       <= 1'b0;
      tick_done_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      bank_q         <= bank_d;
      axon_q         <= axon_d;
      burst_q        <= burst_d;
      gap_q          <= gap_d;
      enable_q       <= (state_d == ISSUE);
      tick_done_q    <= (state_q == SEARCH) && !enc_found;
      tick_overrun_q <= bus.tick && (state_q != IDLE);
    end
  end

  assign bus.axon_number  = axon_q;
  assign bus.enable       = enable_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.tick_done    = tick_done_q;
  assign bus.tick_overrun = tick_overrun_q;
  assign bus.dbg_state    = state_q;
  // Done belongs in the first GAP cycle only; missing there or present in ISSUE/SEARCH/IDLE is an error.
  assign bus.sync_error   = ((state_q == GAP) && (gap_q == '0) && !bus.synap_con_done) ||
                            (bus.synap_con_done && (state_q != GAP));
endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed bench for axon_spike_scheduler with a synapse-stage done model and a burst monitor.
module tb_axon_spike_scheduler;
  import axon_spike_scheduler_pkg::*;

  localparam int NN = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  logic [AXON_W-1:0] exp_q[$];
  int   n_bursts = 0;
  int   sync_cnt = 0;
  int   ov_cnt   = 0;
  int   run      = 0;
  logic [AXON_W-1:0] burst_ax = '0;
  logic prev_en   = 1'b0;
  int   syn_cnt   = 0;
  logic done_pend = 1'b0;
  logic suppress  = 1'b0;

  axon_spike_scheduler_if bus();

  axon_spike_scheduler #(.NUM_NEURONS(NN), .ISSUE_GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_spike(input int ax);
    bus.spike_in_valid = 1'b1;
    bus.spike_in_axon  = AXON_W'(ax);
    step();
    bus.spike_in_valid = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic wait_tick_done(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.tick_done === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // Synapse-stage model: counts enable cycles and answers with done in the following cycle.
  always @(negedge clk) begin
    if (!rst) begin
      syn_cnt   = 0;
      done_pend = 1'b0;
    end else if (bus.enable === 1'b1) begin
      syn_cnt++;
      if (syn_cnt == NN) begin
        syn_cnt = 0;
        if (suppress) suppress = 1'b0;
        else          done_pend = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.synap_con_done = rst ? done_pend : 1'b0;
    done_pend = 1'b0;
  end

  // Burst monitor: replay order against exp_q, burst length, axon stability, pulse counts.
  always @(negedge clk) begin
    if (!rst) begin
      run     = 0;
      prev_en = 1'b0;
    end else begin
      if (bus.enable === 1'b1) begin
        if (run == 0) begin
          int exp_ax;
          n_bursts++;
          exp_ax = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
          chk("burst_axon", 32'(bus.axon_number), 32'(exp_ax));
          burst_ax = bus.axon_number;
        end else begin
          chk("axon_stable", 32'(bus.axon_number), 32'(burst_ax));
        end
        run++;
      end else if (run > 0) begin
        chk("burst_len", 32'(run), 32'(NN));
        run = 0;
      end
      if (bus.sync_error === 1'b1) begin
        sync_cnt++;
        chk("sync_err_first_gap", {30'd0, prev_en, bus.enable}, 32'b10);
      end
      if (bus.tick_overrun === 1'b1) ov_cnt++;
      prev_en = bus.enable;
    end
  end

  initial begin
    int b0, ov0, s0;
    bus.spike_in_valid = 1'b0;
    bus.spike_in_axon  = '0;
    bus.tick           = 1'b0;
    bus.synap_con_done = 1'b0;

    step();
    step();
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tick_done", 32'(bus.tick_done), 32'd0);
    chk("rst_overrun", 32'(bus.tick_overrun), 32'd0);
    chk("rst_sync_error", 32'(bus.sync_error), 32'd0);
    chk("rst_axon", 32'(bus.axon_number), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst = 1'b1;
    step();

    // Spikes 5, 200, 5 then tick: two bursts in ascending order.
    send_spike(5);
    send_spike(200);
    send_spike(5);
    exp_q.push_back(AXON_W'(5));
    exp_q.push_back(AXON_W'(200));
    b0 = n_bursts;
    tick_pulse();
    chk("t1_search_enable", 32'(bus.enable), 32'd0);
    chk("t1_search_busy", 32'(bus.busy), 32'd1);
    step();
    chk("t1_first_enable", 32'(bus.enable), 32'd1);
    chk("t1_first_axon", 32'(bus.axon_number), 32'd5);
    wait_tick_done(1000, "t1_tick_done");
    chk("t1_bursts", 32'(n_bursts - b0), 32'd2);
    chk("t1_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_axon_held", 32'(bus.axon_number), 32'd200);
    chk("t1_no_sync_err", 32'(sync_cnt), 32'd0);
    step();
    chk("t1_tick_done_pulse", 32'(bus.tick_done), 32'd0);
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // Empty tick: busy one cycle, tick_done two cycles after tick.
    b0 = n_bursts;
    tick_pulse();
    chk("t2_busy", 32'(bus.busy), 32'd1);
    chk("t2_done_early", 32'(bus.tick_done), 32'd0);
    step();
    chk("t2_tick_done", 32'(bus.tick_done), 32'd1);
    chk("t2_busy_low", 32'(bus.busy), 32'd0);
    chk("t2_enable", 32'(bus.enable), 32'd0);
    step();
    chk("t2_done_low", 32'(bus.tick_done), 32'd0);
    chk("t2_no_burst", 32'(n_bursts - b0), 32'd0);

    // Spike in the swap cycle belongs to the next tick.
    b0 = n_bursts;
    bus.tick           = 1'b1;
    bus.spike_in_valid = 1'b1;
    bus.spike_in_axon  = AXON_W'(7);
    step();
    bus.tick           = 1'b0;
    bus.spike_in_valid = 1'b0;
    wait_tick_done(10, "t3_first_done");
    chk("t3_no_burst", 32'(n_bursts - b0), 32'd0);
    exp_q.push_back(AXON_W'(7));
    tick_pulse();
    wait_tick_done(600, "t3_second_done");
    chk("t3_one_burst", 32'(n_bursts - b0), 32'd1);
    chk("t3_axon", 32'(bus.axon_number), 32'd7);

    // Tick while busy: overrun pulse, fill bank keeps the new spike.
    b0 = n_bursts;
    ov0 = ov_cnt;
    send_spike(10);
    exp_q.push_back(AXON_W'(10));
    tick_pulse();
    repeat (50) step();
    chk("t4_mid_enable", 32'(bus.enable), 32'd1);
    bus.spike_in_valid = 1'b1;
    bus.spike_in_axon  = AXON_W'(20);
    bus.tick           = 1'b1;
    step();
    bus.tick           = 1'b0;
    bus.spike_in_valid = 1'b0;
    chk("t4_overrun", 32'(bus.tick_overrun), 32'd1);
    chk("t4_enable_kept", 32'(bus.enable), 32'd1);
    step();
    chk("t4_overrun_pulse", 32'(bus.tick_overrun), 32'd0);
    wait_tick_done(600, "t4_first_done");
    chk("t4_ov_count", 32'(ov_cnt - ov0), 32'd1);
    chk("t4_one_burst", 32'(n_bursts - b0), 32'd1);
    exp_q.push_back(AXON_W'(20));
    tick_pulse();
    wait_tick_done(600, "t4_second_done");
    chk("t4_two_bursts", 32'(n_bursts - b0), 32'd2);
    chk("t4_no_sync_err", 32'(sync_cnt), 32'd0);

    // Suppressed done gives exactly one sync_error.
    s0 = sync_cnt;
    suppress = 1'b1;
    send_spike(3);
    exp_q.push_back(AXON_W'(3));
    tick_pulse();
    wait_tick_done(600, "t5_done");
    chk("t5_sync_err", 32'(sync_cnt - s0), 32'd1);
    chk("t5_suppress_used", 32'(suppress), 32'd0);

    // Reset mid-burst drops everything.
    send_spike(1);
    send_spike(2);
    exp_q.push_back(AXON_W'(1));
    tick_pulse();
    repeat (20) step();
    chk("t6_enable_before", 32'(bus.enable), 32'd1);
    chk("t6_axon_before", 32'(bus.axon_number), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_enable_rst", 32'(bus.enable), 32'd0);
    chk("t6_busy_rst", 32'(bus.busy), 32'd0);
    chk("t6_axon_rst", 32'(bus.axon_number), 32'd0);
    chk("t6_tick_done_rst", 32'(bus.tick_done), 32'd0);
    chk("t6_sync_rst", 32'(bus.sync_error), 32'd0);
    step();
    rst = 1'b1;
    step();
    b0 = n_bursts;
    tick_pulse();
    wait_tick_done(10, "t6_done");
    chk("t6_no_burst", 32'(n_bursts - b0), 32'd0);
    chk("t6_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
